// File: rtl/morse_pkg.sv
// Shared Morse-domain constants: control characters and the arbiter state encoding.
// The serializer and FIFO wrappers import the same definitions.
package morse_pkg;

    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_NUL = 8'h00;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first asserted request after `last`, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic               found,
    output logic [IW-1:0]      idx
);

    logic [IW-1:0] cand;

    // Walk from the farthest candidate back to last+1 so the nearest one is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/morse_arbiter.sv
// Whole-message round-robin arbiter in front of the single Morse serializer.
// Ownership ends on LF or owner-idle timeout; a silent gap separates owners.
module morse_arbiter
    import morse_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 63,
    parameter int GAP_CYCLES   = 7
) (
    input  logic                 clk_morse,
    input  logic                 arst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_char,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [7:0]           out_char,
    input  logic                 out_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam arb_state_e    REL_STATE = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;

    arb_state_e    state, state_d;
    logic [IW-1:0] owner, owner_d, last, last_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [GW-1:0] gcnt, gcnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          own_valid;
    logic [7:0]    own_char;
    logic          release_now;

    rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .req   (req_valid),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign own_valid = req_valid[owner];
    assign own_char  = req_char[8*int'(owner) +: 8];
    assign busy      = (state != ARB_IDLE);

    always_ff @(posedge clk_morse or negedge arst_n) begin
        if (!arst_n) begin
            state <= ARB_IDLE;
            owner <= '0;
            last  <= IW'(NUM_REQ - 1);
            tcnt  <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            last  <= last_d;
            tcnt  <= tcnt_d;
            gcnt  <= gcnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        owner_d     = owner;
        last_d      = last;
        tcnt_d      = tcnt;
        gcnt_d      = gcnt;
        out_valid   = 1'b0;
        out_char    = ASCII_NUL;
        req_ready   = '0;
        grant       = '0;
        release_now = 1'b0;

        unique case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_OWN;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    tcnt_d  = '0;
                end
            end
            ARB_OWN: begin
                grant[owner] = 1'b1;
                if (own_valid) begin
                    if (own_char == ASCII_LF) begin
                        req_ready[owner] = 1'b1;
                        release_now      = 1'b1;
                    end else if (own_char == ASCII_NUL) begin
                        req_ready[owner] = 1'b1;
                        tcnt_d           = '0;
                    end else begin
                        // A stall (out_ready low) leaves tcnt untouched.
                        out_valid        = 1'b1;
                        out_char         = own_char;
                        req_ready[owner] = out_ready;
                        if (out_ready) tcnt_d = '0;
                    end
                end else if (tcnt == TMO_LAST) begin
                    release_now = 1'b1;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
                if (release_now) begin
                    state_d = REL_STATE;
                    tcnt_d  = '0;
                    gcnt_d  = '0;
                end
            end
            ARB_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_d = ARB_IDLE;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt + GW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule
